// File: rtl/gps_dump_fifo.sv
// gps_dump_fifo: captures E/P/L correlator accumulators on each dump pulse
// and buffers them as whole 7-word records. Words are streamed out one
// at a time over a valid/ready interface.
// Record layout: w0 = {overflow count, sequence number}, w1..w6 = IE, QE,
// IP, QP, IL, QL, each sign-extended to 32 bits.
module gps_dump_fifo #(
  parameter int ACC_W = 18,
  parameter int DEPTH = 8,
  parameter int SEQ_W = 16
) (
  input  logic                     samp_clk,
  input  logic                     samp_rstn,
  input  logic                     clear,
  input  logic                     dump_pulse,
  input  logic [ACC_W-1:0]         i_early,
  input  logic [ACC_W-1:0]         q_early,
  input  logic [ACC_W-1:0]         i_prompt,
  input  logic [ACC_W-1:0]         q_prompt,
  input  logic [ACC_W-1:0]         i_late,
  input  logic [ACC_W-1:0]         q_late,
  output logic                     rd_valid,
  output logic [31:0]              rd_data,
  output logic                     rd_last,
  input  logic                     rd_ready,
  output logic [$clog2(DEPTH):0]   fifo_level,
  output logic [15:0]              overflow_cnt,
  output logic [SEQ_W-1:0]         seq
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;
  localparam int AW = $clog2(7 * DEPTH);

  // Sign-extend one accumulator to a full 32-bit record word.
  function automatic logic [31:0] sext_acc(input logic [ACC_W-1:0] v);
    return {{(32 - ACC_W){v[ACC_W-1]}}, v};
  endfunction

  logic [31:0]     mem [7*DEPTH];
  logic [PW-1:0]   wr_ptr_r;
  logic [PW-1:0]   rd_ptr_r;
  logic [2:0]      word_idx_r;
  logic [LW-1:0]   level_r;
  logic [SEQ_W-1:0] seq_r;
  logic [15:0]     ovf_r;

  logic            full_s;
  logic            push_s;
  logic            hs_s;
  logic            pop_last_s;
  logic            accept_s;
  logic            drop_s;
  logic [SEQ_W-1:0] seq_next_s;
  logic [AW-1:0]   wr_base_s;
  logic [AW-1:0]   rd_addr_s;
  logic [31:0]     rec_s [7];

  // Push/pop qualification. A flush suppresses both the dump and the handshake.
  always_comb begin
    full_s     = (level_r == LW'(DEPTH));
    push_s     = dump_pulse && !clear;
    hs_s       = (level_r != {LW{1'b0}}) && rd_ready && !clear;
    pop_last_s = hs_s && (word_idx_r == 3'd6);
    accept_s   = push_s && (!full_s || pop_last_s);
    drop_s     = push_s && !accept_s;
    seq_next_s = seq_r + {{(SEQ_W-1){1'b0}}, 1'b1};
    wr_base_s  = AW'(wr_ptr_r) * AW'(3'd7);
    rd_addr_s  = AW'(rd_ptr_r) * AW'(3'd7) + AW'(word_idx_r);
  end

  // Assemble the record that a dump would write this cycle.
  always_comb begin
    rec_s[0] = {ovf_r, 16'(seq_next_s)};
    rec_s[1] = sext_acc(i_early);
    rec_s[2] = sext_acc(q_early);
    rec_s[3] = sext_acc(i_prompt);
    rec_s[4] = sext_acc(q_prompt);
    rec_s[5] = sext_acc(i_late);
    rec_s[6] = sext_acc(q_late);
  end

  // Record storage: a whole record is written in a single cycle.
  // The write slot is never the head slot unless the head is also retiring.
  always_ff @(posedge samp_clk) begin
    if (accept_s) begin
      for (int w = 0; w < 7; w++) begin
        mem[wr_base_s + AW'(w)] <= rec_s[w];
      end
    end
  end

  // Pointers, word index, occupancy, sequence and overflow counters.
  always_ff @(posedge samp_clk or negedge samp_rstn) begin
    if (!samp_rstn) begin
      wr_ptr_r   <= {PW{1'b0}};
      rd_ptr_r   <= {PW{1'b0}};
      word_idx_r <= 3'd0;
      level_r    <= {LW{1'b0}};
      seq_r      <= {SEQ_W{1'b0}};
      ovf_r      <= 16'd0;
    end else if (clear) begin
      wr_ptr_r   <= {PW{1'b0}};
      rd_ptr_r   <= {PW{1'b0}};
      word_idx_r <= 3'd0;
      level_r    <= {LW{1'b0}};
      seq_r      <= {SEQ_W{1'b0}};
      ovf_r      <= 16'd0;
    end else begin
      if (accept_s) begin
        wr_ptr_r <= wr_ptr_r + {{(PW-1){1'b0}}, 1'b1};
      end
      if (hs_s) begin
        if (word_idx_r == 3'd6) begin
          word_idx_r <= 3'd0;
          rd_ptr_r   <= rd_ptr_r + {{(PW-1){1'b0}}, 1'b1};
        end else begin
          word_idx_r <= word_idx_r + 3'd1;
        end
      end
      if (accept_s && !pop_last_s) begin
        level_r <= level_r + {{(LW-1){1'b0}}, 1'b1};
      end else if (pop_last_s && !accept_s) begin
        level_r <= level_r - {{(LW-1){1'b0}}, 1'b1};
      end else begin
        level_r <= level_r;
      end
      if (push_s) begin
        seq_r <= seq_next_s;
      end
      if (drop_s && (ovf_r != 16'hFFFF)) begin
        ovf_r <= ovf_r + 16'd1;
      end
    end
  end

  // Read side is combinational from the head pointer and word index; it
  // forces zeros whenever no record is held (including during reset).
  always_comb begin
    rd_valid = (level_r != {LW{1'b0}});
    if (rd_valid) begin
      rd_data = mem[rd_addr_s];
      rd_last = (word_idx_r == 3'd6);
    end else begin
      rd_data = 32'd0;
      rd_last = 1'b0;
    end
  end

  assign fifo_level   = level_r;
  assign overflow_cnt = ovf_r;
  assign seq          = seq_r;

endmodule

// File: doc/gps_dump_fifo.md
Name: gps_dump_fifo

Overview:
- Sits directly downstream of gps_ca_correlator_channel in the samp_clk domain.
- On each dump_pulse it snapshots the six E/P/L accumulators together with a dump sequence number.
- Snapshots are buffered as whole records in a DEPTH-entry FIFO, so that slow AXI-side polling loses no integration periods.
- Records are read out one 32-bit word at a time over a valid/ready stream that feeds the AXI wrapper readback path.

Parameters:
- ACC_W, 18: width of each signed accumulator input.
- DEPTH, 8: number of record slots; must be a power of 2 and at least 2.
- SEQ_W, 16: width of the dump sequence counter; SEQ_W is at most 16.

Ports:
- samp_clk  in  1  sample clock; all logic is on the rising edge.
- samp_rstn  in  1  reset, asynchronous, active-low.
- clear  in  1  synchronous flush.
- dump_pulse  in  1  one-cycle strobe from the correlator; accumulators are valid in the same cycle.
- i_early, q_early, i_prompt, q_prompt, i_late, q_late  in  ACC_W each  signed accumulators.
- rd_valid  out  1  a record word is available.
- rd_data  out  32  current record word.
- rd_last  out  1  high when the current word is word 6 of the record.
- rd_ready  in  1  consumer accepts the word.
- fifo_level  out  $clog2(DEPTH)+1  number of complete records held.
- overflow_cnt  out  16  number of dumps dropped because the FIFO was full; saturates.
- seq  out  SEQ_W  dump sequence counter, including dropped dumps.

Behaviour:
- Reset (samp_rstn low, asynchronous): pointers, word index, fifo_level, seq and overflow_cnt all go to 0. rd_valid, rd_last and rd_data drive 0. Reset may arrive mid-record; no partial state survives it.
- Record layout, one FIFO entry of 7 words:
  - w0 = {overflow_cnt value at capture, zero-extended seq after increment}.
  - w1..w6 = IE, QE, IP, QP, IL, QL, each sign-extended from ACC_W to 32 bits.
- Push, on dump_pulse:
  - seq increments every time, wrapping modulo 2^SEQ_W. The first dump after reset carries seq = 1.
  - If the FIFO is not full, or a pop of the final word completes in the same cycle, the record is written and fifo_level updates at the next edge.
  - Otherwise the record is dropped and overflow_cnt increments, saturating at 0xFFFF.
- Latency: dump_pulse into an empty FIFO gives rd_valid = 1 on the following cycle, with w0 on rd_data.
- Read handshake:
  - rd_valid = (fifo_level != 0).
  - rd_data and rd_last are driven combinationally from rd_ptr and word_idx. They hold stable while rd_valid && !rd_ready.
  - On rd_valid && rd_ready, word_idx advances.
  - On word 6 (rd_last), word_idx returns to 0, rd_ptr increments modulo DEPTH and fifo_level decrements.
  - The consumer may stall indefinitely between words; there is no timeout.
- Simultaneous push and final-word pop: fifo_level is unchanged, both take effect, and no overflow is counted even when the FIFO was full.
- Push and a mid-record pop: the head record is unaffected, because the write slot is never the head slot when not full.
- clear:
  - Next edge zeroes pointers, word_idx, fifo_level, seq and overflow_cnt.
  - clear wins over a coincident dump_pulse, which is discarded without counting.
  - A handshake coincident with clear is discarded.
- Full: fifo_level == DEPTH. Empty: fifo_level == 0, so rd_valid = 0 and rd_last = 0.
- Storage: 7*DEPTH x 32 register array or inferred RAM. Reads are asynchronous, or registered with equivalent visible behaviour.

Test Plan:
1. Single dump: after reset, pulse with IE=-5, QE=3, IP=131071, QP=-131072, IL=0, QL=1 and rd_ready=1.
   - Response: 7 words on consecutive cycles: 0x00000001, 0xFFFFFFFB, 0x00000003, 0x0001FFFF, 0xFFFE0000, 0x00000000, 0x00000001.
   - rd_last only on the 7th word; fifo_level back to 0.
2. Backpressure: rd_ready toggling 1,0,0,1 per cycle.
   - Response: rd_data is unchanged across stall cycles, each word appears exactly once, and the order is intact.
3. Overflow: rd_ready=0, 10 dumps with DEPTH=8.
   - Response: fifo_level=8, overflow_cnt=2, seq=10.
   - Draining yields seq 1..8; w0 of record 8 reads 0x00000008.
4. Full, with push and final-word pop in the same cycle.
   - Response: record accepted, fifo_level stays 8, overflow_cnt is unchanged.
5. clear mid-record, after w3 has been accepted, coincident with dump_pulse.
   - Response: next cycle rd_valid=0, seq=0 and overflow_cnt=0.
   - The next dump yields w0=0x00000001 and readout starts at w0.
6. Asynchronous reset pulse between clock edges mid-read.
   - Response: outputs go to 0 immediately.
   - Seq wrap: with SEQ_W=4, 17 dumps taken without overflow (rd_ready held 1) give seq 1..15, 0, 1 in w0[15:0].
